// File: rtl/fir_coeff_loader.sv
// Streams NUM_TAPS coefficients into a FIR filter, then drives zero samples for FLUSH_CYCLES.
// Optional macro COEFF_SUM_EN adds a signed checksum output of the accepted coefficients.
module fir_coeff_loader #(
    parameter int NUM_TAPS     = 71,
    parameter int FLUSH_CYCLES = 150,
    parameter int COEFF_W      = 8,
    parameter int ADDR_W       = 7,
    parameter int SAMPLE_W     = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load_start,
    input  logic                cfg_valid,
    input  logic [COEFF_W-1:0]  cfg_data,
    output logic                cfg_ready,
    input  logic [SAMPLE_W-1:0] sample_raw,
    output logic [SAMPLE_W-1:0] sample_in,
    output logic                coeff_write,
    output logic [ADDR_W-1:0]   coeff_addr,
    output logic [COEFF_W-1:0]  coeff_in,
    output logic                busy,
    output logic                done,
`ifdef COEFF_SUM_EN
    output logic [COEFF_W+6:0]  coeff_sum,
`endif
    output logic [1:0]          state_dbg
);

    // Handshake: a coefficient moves when cfg_valid & cfg_ready are both high at a rising edge;
    // cfg_ready depends only on the state register, never on cfg_valid.
    localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);
    localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(NUM_TAPS - 1);
    localparam logic [CNT_W-1:0]  LAST_FLUSH = CNT_W'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] idx;
    logic [CNT_W-1:0]  flush_cnt;
    logic              accept;

    assign cfg_ready = (state == LOAD);
    assign accept    = cfg_valid & cfg_ready;
    assign state_dbg = state;

    // sample_in is chosen from the state being entered so it is zero for every LOAD/FLUSH cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= '0;
            flush_cnt   <= '0;
            coeff_write <= 1'b0;
            coeff_addr  <= '0;
            coeff_in    <= '0;
            sample_in   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            coeff_write <= 1'b0;
            done        <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_start) begin
                        state     <= LOAD;
                        idx       <= '0;
                        busy      <= 1'b1;
                        sample_in <= '0;
                    end else begin
                        sample_in <= sample_raw;
                    end
                end
                LOAD: begin
                    sample_in <= '0;
                    if (accept) begin
                        coeff_write <= 1'b1;
                        coeff_addr  <= idx;
                        coeff_in    <= cfg_data;
                        if (idx == LAST_IDX) begin
                            state     <= FLUSH;
                            flush_cnt <= '0;
                        end else begin
                            idx <= idx + ADDR_W'(1);
                        end
                    end
                end
                FLUSH: begin
                    if (flush_cnt == LAST_FLUSH) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        sample_in <= sample_raw;
                    end else begin
                        flush_cnt <= flush_cnt + CNT_W'(1);
                        sample_in <= '0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    sample_in <= '0;
                end
            endcase
        end
    end

`ifdef COEFF_SUM_EN
    localparam int SUM_W = COEFF_W + 7;

    always_ff @(posedge clk) begin
        if (rst) begin
            coeff_sum <= '0;
        end else if (state == IDLE && load_start) begin
            coeff_sum <= '0;
        end else if (accept) begin
            coeff_sum <= coeff_sum + SUM_W'($signed(cfg_data));
        end
    end
`endif

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Self-checking bench for fir_coeff_loader: write scoreboard, flush/done timing, samples, reset abort.
// Checksum comparisons are compiled in when COEFF_SUM_EN is defined.
module tb_fir_coeff_loader;
    localparam int NUM_TAPS     = 71;
    localparam int FLUSH_CYCLES = 150;
    localparam int W            = 15;

    logic       clk = 1'b0;
    logic       rst;
    logic       load_start;
    logic       cfg_valid;
    logic [7:0] cfg_data;
    logic       cfg_ready;
    logic [3:0] sample_raw;
    logic [3:0] sample_in;
    logic       coeff_write;
    logic [6:0] coeff_addr;
    logic [7:0] coeff_in;
    logic       busy;
    logic       done;
    logic [1:0] state_dbg;
`ifdef COEFF_SUM_EN
    logic [14:0] coeff_sum;
`endif

    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_e;
    int checks   = 0;
    int errors   = 0;
    int done_cnt = 0;
    int exp_done = 0;
    int exp_sum  = 0;

    fir_coeff_loader #(
        .NUM_TAPS(NUM_TAPS), .FLUSH_CYCLES(FLUSH_CYCLES),
        .COEFF_W(8), .ADDR_W(7), .SAMPLE_W(4)
    ) dut (
        .clk(clk), .rst(rst), .load_start(load_start),
        .cfg_valid(cfg_valid), .cfg_data(cfg_data), .cfg_ready(cfg_ready),
        .sample_raw(sample_raw), .sample_in(sample_in),
        .coeff_write(coeff_write), .coeff_addr(coeff_addr), .coeff_in(coeff_in),
        .busy(busy), .done(done),
`ifdef COEFF_SUM_EN
        .coeff_sum(coeff_sum),
`endif
        .state_dbg(state_dbg)
    );

    // clock
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_sum();
`ifdef COEFF_SUM_EN
        check_eq("coeff_sum", int'($signed(coeff_sum)), exp_sum);
`endif
    endtask

    // write monitor: every coeff_write must match the oldest expected accept
    always @(negedge clk) begin
        if (coeff_write) begin
            if (exp_q.size() == 0) begin
                check_eq("wr_unexpected", 32'd1, 32'd0);
            end else begin
                exp_e = exp_q.pop_front();
                check_eq("wr_addr", 32'(coeff_addr), 32'(exp_e[14:8]));
                check_eq("wr_data", 32'(coeff_in), 32'(exp_e[7:0]));
            end
        end
        if (done) done_cnt++;
    end

    // Starts at a negedge in IDLE, returns at the negedge where done should be high.
    // mode: 0 ramp, 1 toggled valid, 2 all -128, 3 all 127, 4 random valid/data
    task automatic run_load(input int mode, input bit poke);
        int n;
        int cyc;
        int d;
        bit v;
        load_start = 1'b1;
        cfg_valid  = 1'b0;
        @(negedge clk);
        load_start = 1'b0;
        check_eq("busy_load", 32'(busy), 32'd1);
        check_eq("state_load", 32'(state_dbg), 32'd1);
        exp_sum = 0;
        n = 0;
        cyc = 0;
        while (n < NUM_TAPS && cyc < 2000) begin
            case (mode)
                0: begin v = 1'b1; d = n; end
                1: begin v = (cyc % 2 == 0); d = int'($urandom_range(0, 255)) - 128; end
                2: begin v = 1'b1; d = -128; end
                3: begin v = 1'b1; d = 127; end
                default: begin v = ($urandom_range(0, 3) != 0); d = int'($urandom_range(0, 255)) - 128; end
            endcase
            check_eq("ready_load", 32'(cfg_ready), 32'd1);
            cfg_valid  = v;
            cfg_data   = 8'(d);
            sample_raw = 4'd1;
            load_start = poke && (cyc == 10);
            if (v) begin
                exp_q.push_back({7'(n), 8'(d)});
                exp_sum += d;
                n++;
            end
            @(negedge clk);
            cyc++;
            check_eq("smp_load", 32'(sample_in), 32'd0);
        end
        load_start = 1'b0;
        check_eq("load_taps", n, NUM_TAPS);
        for (int k = 0; k < FLUSH_CYCLES; k++) begin
            check_eq("busy_flush", 32'(busy), 32'd1);
            check_eq("ready_flush", 32'(cfg_ready), 32'd0);
            check_eq("done_flush", 32'(done), 32'd0);
            check_eq("smp_flush", 32'(sample_in), 32'd0);
            cfg_valid  = 1'b1;
            cfg_data   = 8'($urandom_range(0, 255));
            sample_raw = 4'd1;
            load_start = poke && (k == 40);
            @(negedge clk);
        end
        load_start = 1'b0;
        cfg_valid  = 1'b0;
        exp_done++;
        check_eq("done_pulse", 32'(done), 32'd1);
        check_eq("busy_idle", 32'(busy), 32'd0);
        check_eq("state_idle", 32'(state_dbg), 32'd0);
        check_eq("smp_after_flush", 32'(sample_in), 32'd1);
        check_eq("q_empty", exp_q.size(), 32'd0);
        check_sum();
    endtask

    task automatic idle_samples();
        logic [3:0] prev;
        sample_raw = 4'd1;
        @(negedge clk);
        check_eq("smp_one", 32'(sample_in), 32'd1);
        sample_raw = 4'hF;
        @(negedge clk);
        check_eq("smp_neg1", 32'(sample_in), 32'hF);
        check_eq("done_low", 32'(done), 32'd0);
        for (int i = 0; i < 4; i++) begin
            prev = 4'($urandom_range(0, 15));
            sample_raw = prev;
            @(negedge clk);
            check_eq("smp_rand", 32'(sample_in), 32'(prev));
        end
    endtask

    task automatic check_reset_outputs();
        check_eq("rst_state", 32'(state_dbg), 32'd0);
        check_eq("rst_write", 32'(coeff_write), 32'd0);
        check_eq("rst_addr", 32'(coeff_addr), 32'd0);
        check_eq("rst_coeff", 32'(coeff_in), 32'd0);
        check_eq("rst_sample", 32'(sample_in), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_ready", 32'(cfg_ready), 32'd0);
        exp_sum = 0;
        check_sum();
    endtask

    // abort a load after 30 accepts
    task automatic reset_abort();
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        for (int i = 0; i < 30; i++) begin
            cfg_valid = 1'b1;
            cfg_data  = 8'(i + 5);
            exp_q.push_back({7'(i), 8'(i + 5)});
            @(negedge clk);
        end
        cfg_valid  = 1'b0;
        sample_raw = 4'd1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_outputs();
        check_eq("rst_q_empty", exp_q.size(), 32'd0);
        @(negedge clk);
        check_eq("rst_smp_idle", 32'(sample_in), 32'd1);
    endtask

    initial begin
        rst        = 1'b1;
        load_start = 1'b0;
        cfg_valid  = 1'b0;
        cfg_data   = 8'h00;
        sample_raw = 4'h5;
        repeat (3) @(negedge clk);
        check_reset_outputs();
        rst = 1'b0;
        @(negedge clk);
        check_eq("smp_first", 32'(sample_in), 32'h5);
        idle_samples();

        run_load(0, 1'b1);
        run_load(1, 1'b0);
        @(negedge clk);
        check_eq("done_one_cycle", 32'(done), 32'd0);
        run_load(2, 1'b0);
        repeat (2) @(negedge clk);
        run_load(3, 1'b0);
        idle_samples();
        reset_abort();
        run_load(0, 1'b0);
        repeat (3) @(negedge clk);
        run_load(4, 1'b0);
        repeat (5) @(negedge clk);
        check_eq("done_count", done_cnt, exp_done);
        check_eq("final_q_empty", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
